// File: rtl/cs_block_checker.sv
// rtl/cs_block_checker.sv - S/PDIF channel-status block collector, A/B comparator and CRCC checker
//
// Ports:
//   clk_60mhz, rst       clock; synchronous active-high reset
//   sub_valid            one-cycle strobe qualifying the sub_* fields
//   sub_channel          0 = channel A, 1 = channel B
//   sub_block_start      subframe carried the Z preamble
//   sub_c                channel-status bit of the subframe
//   sub_parity_ok        subframe parity check passed
//   cs_data              last completed channel-A block, bit 0 first transmitted
//   cs_valid             one-cycle pulse when cs_data/crc_*/ab_mismatch update
//   crc_present          professional-format flag (cs_data[0])
//   crc_ok               CRCC matched (0 for consumer format)
//   ab_mismatch          channel-B block differed from channel A
//   block_err            one-cycle pulse when a partial block is aborted
//   locked               high while collecting or awaiting the next Z
//   parity_err_count     saturating count of parity-failed strobes

module cs_block_checker #(
    parameter int FRAMES   = 192,
    parameter int ERRCNT_W = 16
) (
    input  logic                clk_60mhz,
    input  logic                rst,
    input  logic                sub_valid,
    input  logic                sub_channel,
    input  logic                sub_block_start,
    input  logic                sub_c,
    input  logic                sub_parity_ok,
    output logic [FRAMES-1:0]   cs_data,
    output logic                cs_valid,
    output logic                crc_present,
    output logic                crc_ok,
    output logic                ab_mismatch,
    output logic                block_err,
    output logic                locked,
    output logic [ERRCNT_W-1:0] parity_err_count
);

    localparam int IDX_W = $clog2(FRAMES);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAMES - 1);
    // Bits from here on are the received CRCC byte, not CRC input.
    localparam logic [IDX_W-1:0] CRC_START = IDX_W'(FRAMES - 8);

    typedef enum logic [1:0] {
        HUNT     = 2'd0,
        COLLECT  = 2'd1,
        EXPECT_Z = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic              expect_b, expect_b_n;
    logic [FRAMES-1:0] a_buf, a_buf_n;
    logic [7:0]        crc, crc_n;
    logic              mism, mism_n;

    logic [FRAMES-1:0] cs_data_n;
    logic              cs_valid_n, crc_present_n, crc_ok_n, ab_mismatch_n, block_err_n;
    logic              start_blk, is_a_z, b_diff;

    // One serial step of G(x) = x^8+x^4+x^3+x^2+1, input bit in transmission order.
    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic d);
        logic fb;
        fb = c[7] ^ d;
        return {c[6:0], 1'b0} ^ (fb ? 8'h1D : 8'h00);
    endfunction

    always_comb begin
        state_n       = state;
        idx_n         = idx;
        expect_b_n    = expect_b;
        a_buf_n       = a_buf;
        crc_n         = crc;
        mism_n        = mism;
        cs_data_n     = cs_data;
        crc_present_n = crc_present;
        crc_ok_n      = crc_ok;
        ab_mismatch_n = ab_mismatch;
        cs_valid_n    = 1'b0;
        block_err_n   = 1'b0;
        start_blk     = 1'b0;
        is_a_z        = !sub_channel && sub_block_start;
        b_diff        = sub_c != a_buf[idx];

        if (sub_valid) begin
            case (state)
                HUNT: begin
                    if (is_a_z) begin
                        start_blk = 1'b1;
                    end
                end
                COLLECT: begin
                    if (!sub_channel) begin
                        if (sub_block_start && idx != '0) begin
                            // Resync: this Z opens a fresh block, no HUNT detour.
                            block_err_n = 1'b1;
                            start_blk   = 1'b1;
                        end else if (expect_b) begin
                            block_err_n = 1'b1;
                            state_n     = HUNT;
                        end else begin
                            a_buf_n[idx] = sub_c;
                            if (idx < CRC_START) begin
                                crc_n = crc_step(crc, sub_c);
                            end
                            expect_b_n = 1'b1;
                        end
                    end else begin
                        if (sub_block_start || !expect_b) begin
                            block_err_n = 1'b1;
                            state_n     = HUNT;
                        end else begin
                            mism_n     = mism | b_diff;
                            expect_b_n = 1'b0;
                            if (idx == LAST_IDX) begin
                                state_n       = EXPECT_Z;
                                cs_valid_n    = 1'b1;
                                cs_data_n     = a_buf;
                                crc_present_n = a_buf[0];
                                // Received CRCC: bit CRC_START is the byte LSB.
                                crc_ok_n      = a_buf[0] && (crc == a_buf[FRAMES-1 -: 8]);
                                ab_mismatch_n = mism | b_diff;
                            end else begin
                                idx_n = idx + 1'b1;
                            end
                        end
                    end
                end
                EXPECT_Z: begin
                    if (is_a_z) begin
                        start_blk = 1'b1;
                    end else begin
                        block_err_n = 1'b1;
                        state_n     = HUNT;
                    end
                end
                default: state_n = HUNT;
            endcase
        end

        if (start_blk) begin
            state_n    = COLLECT;
            idx_n      = '0;
            expect_b_n = 1'b1;
            a_buf_n[0] = sub_c;
            crc_n      = crc_step(8'hFF, sub_c);
            mism_n     = 1'b0;
        end
    end

    always_ff @(posedge clk_60mhz) begin
        if (rst) begin
            state       <= HUNT;
            idx         <= '0;
            expect_b    <= 1'b0;
            a_buf       <= '0;
            crc         <= 8'hFF;
            mism        <= 1'b0;
            cs_data     <= '0;
            cs_valid    <= 1'b0;
            crc_present <= 1'b0;
            crc_ok      <= 1'b0;
            ab_mismatch <= 1'b0;
            block_err   <= 1'b0;
            locked      <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            expect_b    <= expect_b_n;
            a_buf       <= a_buf_n;
            crc         <= crc_n;
            mism        <= mism_n;
            cs_data     <= cs_data_n;
            cs_valid    <= cs_valid_n;
            crc_present <= crc_present_n;
            crc_ok      <= crc_ok_n;
            ab_mismatch <= ab_mismatch_n;
            block_err   <= block_err_n;
            locked      <= (state_n != HUNT);
        end
    end

    always_ff @(posedge clk_60mhz) begin
        if (rst) begin
            parity_err_count <= '0;
        end else if (sub_valid && !sub_parity_ok && parity_err_count != '1) begin
            parity_err_count <= parity_err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_cs_block_checker.sv
// tb/tb_cs_block_checker.sv - directed scoreboard bench for cs_block_checker

module tb_cs_block_checker;

    logic         clk_60mhz = 1'b0;
    logic         rst = 1'b1;
    logic         sub_valid = 1'b0;
    logic         sub_channel = 1'b0;
    logic         sub_block_start = 1'b0;
    logic         sub_c = 1'b0;
    logic         sub_parity_ok = 1'b1;

    logic [191:0] cs_data;
    logic         cs_valid, crc_present, crc_ok, ab_mismatch, block_err, locked;
    logic [15:0]  parity_err_count;

    logic [191:0] cs_data4;
    logic         cs_valid4, crc_present4, crc_ok4, ab_mismatch4, block_err4, locked4;
    logic [3:0]   parity_err_count4;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit           is_err;
        logic [191:0] data;
        logic         cp;
        logic         ok;
        logic         mm;
    } exp_t;

    exp_t sb[$];

    always #8 clk_60mhz = ~clk_60mhz;

    cs_block_checker #(.FRAMES(192), .ERRCNT_W(16)) u_dut (
        .clk_60mhz(clk_60mhz), .rst(rst), .sub_valid(sub_valid), .sub_channel(sub_channel),
        .sub_block_start(sub_block_start), .sub_c(sub_c), .sub_parity_ok(sub_parity_ok),
        .cs_data(cs_data), .cs_valid(cs_valid), .crc_present(crc_present), .crc_ok(crc_ok),
        .ab_mismatch(ab_mismatch), .block_err(block_err), .locked(locked),
        .parity_err_count(parity_err_count)
    );

    cs_block_checker #(.FRAMES(192), .ERRCNT_W(4)) u_dut4 (
        .clk_60mhz(clk_60mhz), .rst(rst), .sub_valid(sub_valid), .sub_channel(sub_channel),
        .sub_block_start(sub_block_start), .sub_c(sub_c), .sub_parity_ok(sub_parity_ok),
        .cs_data(cs_data4), .cs_valid(cs_valid4), .crc_present(crc_present4), .crc_ok(crc_ok4),
        .ab_mismatch(ab_mismatch4), .block_err(block_err4), .locked(locked4),
        .parity_err_count(parity_err_count4)
    );

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference CRCC: bitwise long division by 0x11D over bits 0..183, init 0xFF.
    function automatic logic [7:0] crc_ref(input logic [191:0] blk);
        logic [8:0] r;
        r = 9'h0FF;
        for (int i = 0; i < 184; i++) begin
            r = {r[7:0], 1'b0};
            if (r[8] ^ blk[i]) r = r ^ 9'h11D;
            r[8] = 1'b0;
        end
        return r[7:0];
    endfunction

    task automatic sub(input logic ch, input logic z, input logic c, input logic pok);
        @(negedge clk_60mhz);
        sub_valid       = 1'b1;
        sub_channel     = ch;
        sub_block_start = z;
        sub_c           = c;
        sub_parity_ok   = pok;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_60mhz);
            sub_valid       = 1'b0;
            sub_block_start = 1'b0;
            sub_parity_ok   = 1'b1;
        end
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1; e.data = '0; e.cp = 1'b0; e.ok = 1'b0; e.mm = 1'b0;
        sb.push_back(e);
    endtask

    task automatic push_blk(input logic [191:0] a, input logic [191:0] b);
        exp_t e;
        e.is_err = 1'b0;
        e.data   = a;
        e.cp     = a[0];
        e.ok     = a[0] && (crc_ref(a) == a[191:184]);
        e.mm     = (a != b);
        sb.push_back(e);
    endtask

    task automatic partial(input logic [191:0] a, input logic [191:0] b, input int n);
        for (int f = 0; f < n; f++) begin
            sub(1'b0, f == 0, a[f], 1'b1);
            sub(1'b1, 1'b0, b[f], 1'b1);
        end
    endtask

    task automatic send_block(input logic [191:0] a, input logic [191:0] b);
        for (int f = 0; f < 192; f++) begin
            sub(1'b0, f == 0, a[f], 1'b1);
            if (f == 191) push_blk(a, b);
            sub(1'b1, 1'b0, b[f], 1'b1);
        end
    endtask

    // Scoreboard consumer: every cs_valid/block_err pulse must match the next expected event.
    always @(negedge clk_60mhz) begin
        if (!rst && (cs_valid === 1'b1 || block_err === 1'b1)) begin
            check("event_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("ev_block_err", block_err, e.is_err);
                check("ev_cs_valid", cs_valid, !e.is_err);
                if (!e.is_err) begin
                    check("ev_cs_data", cs_data, e.data);
                    check("ev_crc_present", crc_present, e.cp);
                    check("ev_crc_ok", crc_ok, e.ok);
                    check("ev_ab_mismatch", ab_mismatch, e.mm);
                end
            end
        end
    end

    initial begin
        logic [191:0] blk, blk2, bb;

        // Reset state
        repeat (3) @(negedge clk_60mhz);
        check("rst_cs_data", cs_data, 0);
        check("rst_cs_valid", cs_valid, 0);
        check("rst_crc_present", crc_present, 0);
        check("rst_crc_ok", crc_ok, 0);
        check("rst_ab_mismatch", ab_mismatch, 0);
        check("rst_block_err", block_err, 0);
        check("rst_locked", locked, 0);
        check("rst_parity_cnt", parity_err_count, 0);
        rst = 1'b0;

        // HUNT ignores strobes without A+Z
        sub(1'b1, 1'b0, 1'b1, 1'b1);
        sub(1'b0, 1'b0, 1'b1, 1'b1);
        idle(2);
        check("hunt_locked", locked, 0);

        // Consumer block, all zero
        send_block('0, '0);
        idle(2);
        check("cons_locked", locked, 1);
        check("cons_crc_ok", crc_ok, 0);

        // Professional block with correct CRCC, directly after the previous one
        blk = '0;
        blk[7:0] = 8'h01;
        blk[191:184] = crc_ref(blk);
        send_block(blk, blk);
        idle(2);
        check("pro_crc_present", crc_present, 1);
        check("pro_crc_ok", crc_ok, 1);

        // Bit 50 corrupted on both channels
        blk2 = blk;
        blk2[50] = ~blk2[50];
        send_block(blk2, blk2);
        idle(2);
        check("pro_bad_crc_ok", crc_ok, 0);
        check("pro_bad_mismatch", ab_mismatch, 0);

        // B differs from A only at bit 37
        for (int i = 0; i < 6; i++) blk[i*32 +: 32] = $urandom();
        bb = blk;
        bb[37] = ~bb[37];
        send_block(blk, bb);
        idle(2);
        check("ab_mismatch", ab_mismatch, 1);
        check("ab_cs_data", cs_data, blk);

        // Z on A at frame 100: resync, the Z frame opens the next block
        partial(bb, bb, 100);
        push_err();
        for (int i = 0; i < 6; i++) blk[i*32 +: 32] = $urandom();
        send_block(blk, blk);
        idle(2);
        check("resync_data", cs_data, blk);

        // Back-to-back A mid-block
        partial(blk, blk, 50);
        sub(1'b0, 1'b0, 1'b0, 1'b1);
        push_err();
        sub(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        check("aa_locked", locked, 0);
        check("aa_cs_data_held", cs_data, blk);
        blk2 = ~blk;
        send_block(blk2, blk2);
        idle(2);
        check("aa_recover_data", cs_data, blk2);

        // B first after the block instead of Z
        push_err();
        sub(1'b1, 1'b0, 1'b0, 1'b1);
        idle(2);
        check("bz_locked", locked, 0);

        // Parity counter and saturation of the 4-bit instance
        for (int i = 0; i < 3; i++) sub(1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        check("parity_cnt3", parity_err_count, 3);
        check("parity4_cnt3", parity_err_count4, 3);
        for (int i = 0; i < 17; i++) sub(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        check("parity_cnt20", parity_err_count, 20);
        check("parity4_sat", parity_err_count4, 4'hF);

        // Reset at frame 80
        partial(blk, blk, 80);
        @(negedge clk_60mhz);
        sub_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk_60mhz);
        check("mrst_cs_data", cs_data, 0);
        check("mrst_crc_present", crc_present, 0);
        check("mrst_crc_ok", crc_ok, 0);
        check("mrst_ab_mismatch", ab_mismatch, 0);
        check("mrst_locked", locked, 0);
        check("mrst_parity_cnt", parity_err_count, 0);
        check("mrst_parity4_cnt", parity_err_count4, 0);
        rst = 1'b0;
        // Back in HUNT: non-Z A and B strobes produce nothing
        sub(1'b0, 1'b0, 1'b1, 1'b1);
        sub(1'b1, 1'b0, 1'b1, 1'b1);
        idle(3);
        check("mrst_hunt_locked", locked, 0);
        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
